// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - LED PWM generator with boundary-shadowed duty and graceful drain.
// Optional macro PWM_FADE_EN: duty_applied steps by one toward duty at each period boundary.
module pwm_gen #(
   parameter int WIDTH = 4
) (
   input  logic             pwm_clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm_out,
   output logic             period_start,
   output logic             busy,
   output logic [WIDTH-1:0] duty_applied
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'((1 << WIDTH) - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             ps_q, ps_d;
   logic [WIDTH-1:0] boundary_duty;
   logic [WIDTH-1:0] start_duty;

`ifdef PWM_FADE_EN
   always_comb begin
      boundary_duty = duty_q;
      if (duty > duty_q) begin
         boundary_duty = duty_q + 1'b1;
      end else if (duty < duty_q) begin
         boundary_duty = duty_q - 1'b1;
      end
      start_duty = duty_q;
   end
`else
   always_comb begin
      boundary_duty = duty;
      start_duty    = duty;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      ps_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d = RUN;
               duty_d  = start_duty;
               ps_d    = 1'b1;
            end
         end
         RUN, DRAIN: begin
            // enable is only decisive at the boundary; mid-period it just tracks RUN/DRAIN
            if (cnt_q == MAX_CNT) begin
               cnt_d = '0;
               if (enable) begin
                  state_d = RUN;
                  duty_d  = boundary_duty;
                  ps_d    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = enable ? RUN : DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      pwm_d = (state_d != IDLE) && (cnt_d < duty_d);
   end

   always_ff @(posedge pwm_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
         ps_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         ps_q    <= ps_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign busy         = (state_q != IDLE);
   assign duty_applied = duty_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen (table vectors, corner sequences, random vs model).
module tb_pwm_gen;

   localparam int PERIOD = 15;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] duty;
   logic       pwm_out;
   logic       period_start;
   logic       busy;
   logic [3:0] duty_applied;

   int total = 0;
   int bad   = 0;

   int m_active  = 0;
   int m_phase   = 0;
   int m_applied = 0;

   typedef struct {
      logic       en;
      logic [3:0] d;
      logic       pwm;
      logic       ps;
      logic       busy;
      logic [3:0] da;
   } vec_t;

   vec_t vecs[16];

   pwm_gen #(.WIDTH(4)) dut (
      .pwm_clk      (clk),
      .reset_n      (rst_n),
      .enable       (en),
      .duty         (duty),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .busy         (busy),
      .duty_applied (duty_applied)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a period is PERIOD cycles long; enable only matters at a period start.
   task automatic model_edge(input logic e, input int d);
      if (m_active == 0) begin
         if (e) begin
            m_active = 1;
            m_phase  = 0;
`ifndef PWM_FADE_EN
            m_applied = d;
`endif
         end
      end else if (m_phase == PERIOD - 1) begin
         m_phase = 0;
         if (e) begin
`ifdef PWM_FADE_EN
            if (d > m_applied) m_applied++;
            else if (d < m_applied) m_applied--;
`else
            m_applied = d;
`endif
         end else begin
            m_active = 0;
         end
      end else begin
         m_phase++;
      end
   endtask

   task automatic step(input logic e, input logic [3:0] d);
      en   = e;
      duty = d;
      @(posedge clk);
      model_edge(e, int'(d));
      @(negedge clk);
      chk("pwm_out", int'(pwm_out), int'(m_active != 0 && m_phase < m_applied));
      chk("period_start", int'(period_start), int'(m_active != 0 && m_phase == 0));
      chk("busy", int'(busy), m_active);
      chk("duty_applied", int'(duty_applied), m_applied);
   endtask

   task automatic run_to_phase(input int p, input logic e, input logic [3:0] d);
      int guard;
      guard = 0;
      while (!(m_active != 0 && m_phase == p) && guard < 40) begin
         step(e, d);
         guard++;
      end
      chk("reach_phase_timeout", int'(guard < 40), 1);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pwm_out", int'(pwm_out), 0);
      chk("rst_period_start", int'(period_start), 0);
      chk("rst_busy", int'(busy), 0);
      m_active  = 0;
      m_phase   = 0;
      m_applied = 0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_duty_applied", int'(duty_applied), 0);
   endtask

   initial begin
      int ones;
      int starts;
      rst_n = 1'b0;
      en    = 1'b0;
      duty  = 4'd0;

      for (int i = 0; i < 16; i++) begin
         vecs[i].en   = 1'b1;
         vecs[i].d    = (i == 0) ? 4'd5 : (i == 15) ? 4'd12 : 4'(i);
         vecs[i].pwm  = (i == 15) ? 1'b1 : (i < 5);
         vecs[i].ps   = (i == 0 || i == 15);
         vecs[i].busy = 1'b1;
         vecs[i].da   = (i == 15) ? 4'd12 : 4'd5;
      end

      repeat (2) @(negedge clk);
      chk("reset_pwm_out", int'(pwm_out), 0);
      chk("reset_period_start", int'(period_start), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_duty_applied", int'(duty_applied), 0);
      rst_n = 1'b1;
      step(1'b0, 4'd5);

`ifndef PWM_FADE_EN
      for (int i = 0; i < 16; i++) begin
         step(vecs[i].en, vecs[i].d);
         chk("vec_pwm", int'(pwm_out), int'(vecs[i].pwm));
         chk("vec_ps", int'(period_start), int'(vecs[i].ps));
         chk("vec_busy", int'(busy), int'(vecs[i].busy));
         chk("vec_da", int'(duty_applied), int'(vecs[i].da));
      end
`endif

      // duty 0 then 15, three full periods each, boundary-aligned
      run_to_phase(PERIOD - 1, 1'b1, 4'd0);
      ones = 0; starts = 0;
      repeat (3 * PERIOD) begin
         step(1'b1, 4'd0);
         ones += int'(pwm_out);
         starts += int'(period_start);
      end
      chk("duty0_high_clocks", ones, 0);
      chk("duty0_starts", starts, 3);
      ones = 0; starts = 0;
      repeat (3 * PERIOD) begin
         step(1'b1, 4'd15);
         ones += int'(pwm_out);
         starts += int'(period_start);
      end
`ifndef PWM_FADE_EN
      chk("duty15_high_clocks", ones, 3 * PERIOD);
`endif
      chk("duty15_starts", starts, 3);

      // duty change mid-period does not disturb the current period
      run_to_phase(PERIOD - 1, 1'b1, 4'd3);
      ones = 0;
      repeat (8) begin
         step(1'b1, 4'd3);
         ones += int'(pwm_out);
      end
      repeat (PERIOD - 8) begin
         step(1'b1, 4'd12);
         ones += int'(pwm_out);
      end
`ifndef PWM_FADE_EN
      chk("mid_change_high_clocks", ones, 3);
`endif
      step(1'b1, 4'd12);
      chk("boundary_ps", int'(period_start), 1);
`ifndef PWM_FADE_EN
      chk("boundary_da", int'(duty_applied), 12);
`endif

      // drop enable at cnt 4: period drains then idles
      run_to_phase(4, 1'b1, 4'd6);
      repeat (PERIOD - 5) step(1'b0, 4'd6);
      chk("drain_still_busy", int'(busy), 1);
      step(1'b0, 4'd6);
      chk("drain_idle_busy", int'(busy), 0);
      chk("drain_idle_pwm", int'(pwm_out), 0);
      chk("drain_idle_ps", int'(period_start), 0);
      step(1'b0, 4'd6);

      // re-raise enable at cnt 9: no gap in the schedule
      step(1'b1, 4'd7);
      run_to_phase(4, 1'b1, 4'd7);
      run_to_phase(8, 1'b0, 4'd7);
      run_to_phase(PERIOD - 1, 1'b1, 4'd7);
      step(1'b1, 4'd7);
      chk("reenable_ps", int'(period_start), 1);
      chk("reenable_busy", int'(busy), 1);

      // asynchronous reset at cnt 2 with duty 8
      run_to_phase(PERIOD - 1, 1'b1, 4'd8);
      run_to_phase(2, 1'b1, 4'd8);
      async_reset();

      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 6) != 0, 4'($urandom_range(0, 15)));
         if (($urandom % 400) == 0) async_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- LED PWM waveform generator driven by the 4-bit brightness count from the button-stepped duty counter.
- Converts a duty value into a fixed-period pulse train on pwm_out.
- Duty changes are shadow-loaded only at period boundaries, so pulses are never glitched.
- Supports graceful start/stop through an enable input and a drain state.

Parameters:
WIDTH, 4, width of duty input and period counter; period = 2^WIDTH-1 clocks (15 at default)
MAX_CNT, 2^WIDTH-2, terminal value of the period counter (derived, localparam)

Ports:
pwm_clk  input  1  block clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  level request to generate PWM
duty  input  WIDTH  requested duty; 0 = always low, 2^WIDTH-1 = always high
pwm_out  output  1  PWM waveform, driven directly from a flop
period_start  output  1  one-cycle pulse in the first cycle (cnt==0) of every active period
busy  output  1  high whenever state != IDLE
duty_applied  output  WIDTH  duty currently in effect (shadow register)

Behaviour:
- Interface: one clock (pwm_clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - state=IDLE; cnt=0; duty_applied=0.
  - pwm_out=0, period_start=0, busy=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - pwm_out=0, cnt held at 0.
  - enable sampled high at an edge: next cycle is cnt=0 of the first period, state=RUN, duty_applied=duty (sampled at that edge), period_start=1.
- RUN:
  - cnt increments by 1 each clock.
  - At cnt==MAX_CNT the next cycle has cnt=0, duty_applied reloads from duty, and period_start=1.
  - enable low in RUN: go to DRAIN; the current period completes unchanged.
- DRAIN:
  - Counting and pwm_out continue as in RUN.
  - enable high again: return to RUN with no phase disturbance.
  - At cnt==MAX_CNT with enable still low: go to IDLE, cnt=0, pwm_out=0, no period_start pulse.
  - duty_applied retains its last value in IDLE.
- Waveform: in the cycle where cnt==k of an active period, pwm_out==1 iff k < duty_applied.
  - pwm_out is registered and aligned with cnt; no combinational path from duty or enable to pwm_out.
  - Period length is exactly MAX_CNT+1 clocks.
  - High time per period is exactly duty_applied clocks, saturating at the full period for duty=2^WIDTH-1.
- Duty changes mid-period never affect the current period; only the value present at the boundary edge is loaded.
- Comparison is unsigned; no wrap.
- Reset mid-period forces all outputs low immediately (asynchronous); restart requires enable.

Optional Feature:
- Macro: PWM_FADE_EN.
- Defined:
  - At each period boundary, duty_applied moves one step toward duty (+1 or -1), and holds if equal.
  - IDLE->RUN start begins from the retained duty_applied value.
  - A full 0->15 ramp takes 15 periods.
- Undefined: duty_applied loads duty directly at each boundary (behaviour above).

Test Plan:
- Reset then enable=1, duty=5 -> period_start one cycle after the enable edge; pwm_out high 5 clocks, low 10, repeating every 15 clocks; busy=1.
- duty=0 and duty=15 each for 3 periods -> pwm_out constant 0 and constant 1 respectively; period_start every 15 clocks.
- RUN with duty=3; change duty to 12 at cnt=7 -> current period keeps 3 high clocks; next period has 12; duty_applied changes in the cycle with period_start=1.
- Drop enable at cnt=4 -> period finishes, then IDLE with pwm_out=0 and busy=0; separately, re-raise enable at cnt=9 -> no gap, next period_start on schedule.
- Assert reset_n low at cnt=2 with duty=8 -> pwm_out, busy, and period_start go 0 asynchronously; duty_applied=0 after release.
- With PWM_FADE_EN: duty applied 0, set duty=4 -> duty_applied reads 1,2,3,4 on four successive period_start pulses, then holds.
